// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down modulo counter with tc pulse, sticky ovf; optional prescaler via COUNTER_PRESCALE_EN
module updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = (1 << WIDTH) - 1,
  parameter int RESET_VAL = 0,
  parameter int PRESC_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up,
  input  logic               clear,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               ovf_clr,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc,
`endif
  output logic [WIDTH-1:0]   out,
  output logic               tc,
  output logic               ovf
);
  localparam logic [WIDTH-1:0] top_v = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] rst_v = WIDTH'(RESET_VAL);
  logic tick, at_end, wrap;
  logic [WIDTH-1:0] nxt;
`ifdef COUNTER_PRESCALE_EN
  logic [PRESC_W-1:0] div;
  assign tick = div == presc;
  always_ff @(posedge clk)
    if (reset || clear || load) div <= '0;
    else if (en) div <= tick ? '0 : div + 1'b1;
`else
  assign tick = PRESC_W != 0;
`endif
  assign at_end = up ? out == top_v : out == '0;
  assign wrap = en & tick & at_end & ~clear & ~load;
  assign nxt = at_end ? (up ? '0 : top_v) : (up ? out + 1'b1 : out - 1'b1);
  always_ff @(posedge clk)
    if (reset) begin
      out <= rst_v;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= clear ? rst_v : load ? (load_val > top_v ? top_v : load_val) : (en & tick) ? nxt : out;
      tc  <= wrap;
      ovf <= wrap | (ovf & ~ovf_clr);
    end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed vector bench for updown_counter (MAX=15 and MAX=9 instances)
module tb_updown_counter;
  typedef struct {
    logic s, rst, en, up, clr, ld;
    logic [3:0] lv;
    logic oc;
    logic [3:0] eo;
    logic et, ev;
  } vec_t;
  vec_t tbl[$];
  logic clk = 1'b0;
  logic sel = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b0, clr = 1'b0, ld = 1'b0, oc = 1'b0;
  logic [3:0] lv = '0;
  logic [3:0] out_a, out_b;
  logic tc_a, tc_b, ovf_a, ovf_b;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  updown_counter dut_a (
    .clk(clk), .reset(rst & ~sel), .en(en & ~sel), .up(up), .clear(clr & ~sel),
    .load(ld & ~sel), .load_val(lv), .ovf_clr(oc & ~sel), .out(out_a), .tc(tc_a), .ovf(ovf_a)
  );
  updown_counter #(.MAX(9)) dut_b (
    .clk(clk), .reset(rst & sel), .en(en & sel), .up(up), .clear(clr & sel),
    .load(ld & sel), .load_val(lv), .ovf_clr(oc & sel), .out(out_b), .tc(tc_b), .ovf(ovf_b)
  );
  function automatic void add(input logic s, r, e, u, c, l, input logic [3:0] v, input logic o,
                              input logic [3:0] eo, input logic et, ev);
    vec_t x;
    x.s = s; x.rst = r; x.en = e; x.up = u; x.clr = c; x.ld = l; x.lv = v; x.oc = o;
    x.eo = eo; x.et = et; x.ev = ev;
    tbl.push_back(x);
  endfunction
  task automatic step(input logic s, r, e, u, c, l, input logic [3:0] v, input logic o);
    sel = s; rst = r; en = e; up = u; clr = c; ld = l; lv = v; oc = o;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [3:0] eo, input logic et, ev);
    logic [3:0] go;
    logic gt, gv;
    go = sel ? out_b : out_a;
    gt = sel ? tc_b : tc_a;
    gv = sel ? ovf_b : ovf_a;
    vecs++;
    if (go !== eo || gt !== et || gv !== ev) begin
      errs++;
      $display("FAIL %s: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b", name, go, gt, gv, eo, et, ev);
    end
  endtask
  initial begin
    //   s  rst en up clr ld  lv  oc  out tc ovf
    add(0, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 4'd7, 0, 4'd7, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd8, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4'd0, 0, 4'd7, 0, 0);
    add(0, 0, 1, 1, 1, 1, 4'd9, 0, 4'd0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4'd0, 0, 4'd15, 1, 1);
    add(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd15, 0, 1);
    add(0, 0, 0, 0, 0, 0, 4'd0, 1, 4'd15, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'd0, 1, 4'd0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 4'd0, 1, 4'd0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4'd3, 0, 4'd3, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4'd0, 0, 4'd3, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd4, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4'd0, 0, 4'd3, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4'd15, 0, 4'd15, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 1, 1);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd1, 0, 1);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd2, 0, 1);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd3, 0, 1);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd4, 0, 1);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd5, 0, 1);
    add(0, 1, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'd0, 0, 4'd1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 4'd0, 0, 4'd9, 1, 1);
    add(1, 0, 1, 0, 0, 0, 4'd0, 0, 4'd8, 0, 1);
    add(1, 0, 1, 0, 0, 1, 4'd12, 0, 4'd9, 0, 1);
    add(1, 0, 0, 0, 0, 0, 4'd0, 1, 4'd9, 0, 0);
    add(1, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 4'd15, 0, 4'd9, 0, 1);
    add(1, 0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 1);
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].oc);
      chk($sformatf("vec%0d", i), tbl[i].eo, tbl[i].et, tbl[i].ev);
    end
    // full up-count through the 15->0 wrap on the 4-bit instance
    step(0, 1, 0, 0, 0, 0, 4'd0, 0);
    step(0, 1, 0, 0, 0, 0, 4'd0, 0);
    chk("up_reset", 4'd0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 1, 0, 0, 4'd0, 0);
      chk($sformatf("up%0d", i), 4'(i % 16), i == 16, i == 16);
    end
    step(0, 0, 1, 1, 0, 0, 4'd0, 0);
    chk("up_after_wrap", 4'd1, 0, 1);
    // down-count on MAX=9 from 0: wraps to 9 twice
    step(1, 1, 0, 0, 0, 0, 4'd0, 0);
    chk("dn_reset", 4'd0, 0, 0);
    for (int i = 0; i <= 10; i++) begin
      step(1, 0, 1, 0, 0, 0, 4'd0, 0);
      chk($sformatf("dn%0d", i), (i == 0 || i == 10) ? 4'd9 : 4'(9 - i), i == 0 || i == 10, 1'b1);
    end
    step(1, 0, 0, 0, 0, 0, 4'd0, 1);
    chk("dn_ovf_clr", 4'd9, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
